// File: rtl/cpu5_dmem_resp_pkg.sv
// Shared constants, state encoding and address decode for the cpu5 data-memory responder.
package cpu5_dmem_resp_pkg;

  localparam int CPU5_XLEN           = 32;
  localparam int CPU5_DMEM_LAT_WIDTH = 4;

  localparam logic [1:0] CPU5_DMEM_IDLE = 2'd0;
  localparam logic [1:0] CPU5_DMEM_WAIT = 2'd1;
  localparam logic [1:0] CPU5_DMEM_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = CPU5_DMEM_IDLE,
    ST_WAIT = CPU5_DMEM_WAIT,
    ST_RESP = CPU5_DMEM_RESP
  } dmem_state_e;

  // Misaligned (low two bits set) or any address bit above the word index set.
  function automatic logic dmem_addr_err(input logic [CPU5_XLEN-1:0] addr, input int aw);
    logic hi;
    hi = 1'b0;
    for (int b = 0; b < CPU5_XLEN; b++) begin
      if (b >= aw + 2) hi = hi | addr[b];
    end
    return (addr[1:0] != 2'b00) | hi;
  endfunction

endpackage

// File: rtl/cpu5_dmem_array.sv
// Word storage for the cpu5 data-memory responder: synchronous write and read, no reset.
module cpu5_dmem_array
  import cpu5_dmem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [CPU5_XLEN-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [CPU5_XLEN-1:0] rdata
);

  logic [CPU5_XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu5_dmem_resp.sv
// Memory-side responder for cpu5 loads/stores: valid/ready request and response,
// programmable wait states, misalignment and range checking.
module cpu5_dmem_resp
  import cpu5_dmem_resp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [CPU5_XLEN-1:0] req_addr,
  input  logic [CPU5_XLEN-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CPU5_XLEN-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CPU5_DMEM_LAT_WIDTH-1:0] LAT_INIT = CPU5_DMEM_LAT_WIDTH'(LATENCY);
  localparam logic [CPU5_DMEM_LAT_WIDTH-1:0] CNT_ONE  = CPU5_DMEM_LAT_WIDTH'(1);

  dmem_state_e                    state;
  logic [CPU5_DMEM_LAT_WIDTH-1:0] cnt;
  logic                           we_q;
  logic                           err_q;
  logic [AW-1:0]                  idx_q;

  logic                 accept;
  logic                 dec_err;
  logic [AW-1:0]        req_idx;
  logic                 arr_we;
  logic                 enter_resp;
  logic [AW-1:0]        rd_idx;
  logic [CPU5_XLEN-1:0] arr_rdata;

  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_ready & req_valid;
  assign dec_err    = dmem_addr_err(req_addr, AW);
  assign req_idx    = req_addr[AW+1:2];
  assign arr_we     = accept & req_we & ~dec_err;
  assign enter_resp = (accept && (LATENCY == 0)) || ((state == ST_WAIT) && (cnt == CNT_ONE));
  // With zero latency the read is issued in the acceptance cycle, before idx_q is loaded.
  assign rd_idx     = (state == ST_IDLE) ? req_idx : idx_q;

  cpu5_dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (req_idx),
    .wdata (req_wdata),
    .re    (enter_resp),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            err_q <= dec_err;
            idx_q <= req_idx;
            cnt   <= LAT_INIT;
            state <= (LATENCY > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= ST_RESP;
        end
        ST_RESP: begin
          // First RESP cycle registers the array read; the response is presented after it.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (we_q | err_q) ? '0 : arr_rdata;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
